memory_cycle_ft: RTL

- Memory-access stage directly downstream of the time-redundant execute stage; consumes its EX/MEM outputs and produces the MEM/WB pipeline register.
- Holds a word-addressed data memory protected by one even-parity bit per word.
- Every store is followed by a one-cycle write-readback verify that stalls the upstream stage.
- Load parity errors, verify mismatches and misaligned accesses raise sticky fault flags, in the same style as the execute-stage ALU and mux fault flags.

---
 rtl/memory_cycle_ft.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_cycle_ft.sv
`default_nettype none
// ============================================================================
//  Module   : memory_cycle_ft
//  Brief    : Memory-access pipeline stage with a parity-protected data
//             memory, a one-cycle write-readback verify after every store,
//             and sticky fault flags for parity, verify and alignment faults.
//  Revision : 1.0 - initial release
// ============================================================================
module memory_cycle_ft #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic        test_en_in,
  output logic        mem_busy,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        parity_err_sticky,
  output logic        verify_err_sticky,
  output logic        align_err_sticky,
  output logic        mem_fault_detected
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_VERIFY = 1'b1
  } state_t;

  // Each entry holds {parity, data}; parity is even parity of the intended data.
  logic [32:0]       mem_q [DEPTH];

  state_t            state_q, state_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic              result_src_w_q, result_src_w_d;
  logic [4:0]        rd_w_q, rd_w_d;
  logic [31:0]       alu_result_w_q, alu_result_w_d;
  logic [31:0]       read_data_w_q, read_data_w_d;
  logic [31:0]       pc_plus4_w_q, pc_plus4_w_d;
  logic              parity_err_q, parity_err_d;
  logic              verify_err_q, verify_err_d;
  logic              align_err_q, align_err_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [31:0]       vdata_q, vdata_d;

  logic [ADDR_W-1:0] addr_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [32:0]       rd_entry;
  logic [31:0]       rd_data;
  logic              rd_par_bad;
  logic              verify_bad;
  logic              misaligned;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [32:0]       mem_wdata;
  logic              unused_addr_bits;

  // Address decode and combinational read path; VERIFY reads the latched store address.
  always_comb begin
    addr_idx   = ALU_ResultM[ADDR_W+1:2];
    misaligned = |ALU_ResultM[1:0];
    rd_addr    = (state_q == S_VERIFY) ? vaddr_q : addr_idx;
    rd_entry   = mem_q[rd_addr];
    rd_data    = rd_entry[31:0];
    rd_par_bad = (^rd_data) != rd_entry[32];
    verify_bad = rd_entry != {^vdata_q, vdata_q};
  end

  // Word-address bits above the array are don't-care.
  assign unused_addr_bits = ^ALU_ResultM[31:ADDR_W+2];

  // Next-state, MEM/WB register, store-verify latch and sticky-flag logic.
  always_comb begin
    state_d        = state_q;
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
    rd_w_d         = rd_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;
    parity_err_d   = parity_err_q;
    verify_err_d   = verify_err_q;
    align_err_d    = align_err_q;
    vaddr_d        = vaddr_q;
    vdata_d        = vdata_q;
    mem_we         = 1'b0;
    mem_waddr      = addr_idx;
    // Fault injection flips stored bit 0 but keeps parity of the true data,
    // so both the readback verify and later loads can see the corruption.
    mem_wdata      = {^WriteDataM, WriteDataM[31:1], WriteDataM[0] ^ test_en_in};

    case (state_q)
      S_IDLE: begin
        reg_write_w_d  = RegWriteM;
        result_src_w_d = ResultSrcM;
        rd_w_d         = RD_M;
        alu_result_w_d = ALU_ResultM;
        pc_plus4_w_d   = PCPlus4M;
        read_data_w_d  = rd_data;

        if (MemWriteM) begin
          if (misaligned) begin
            align_err_d   = 1'b1;
            reg_write_w_d = 1'b0;
          end else begin
            mem_we  = 1'b1;
            vaddr_d = addr_idx;
            vdata_d = WriteDataM;
            state_d = S_VERIFY;
          end
        end

        if (ResultSrcM) begin
          if (misaligned) begin
            align_err_d   = 1'b1;
            read_data_w_d = 32'd0;
            reg_write_w_d = 1'b0;
          end else if (rd_par_bad) begin
            parity_err_d = 1'b1;
          end
        end
      end

      S_VERIFY: begin
        // Bubble into WB while the upstream holds the next instruction.
        reg_write_w_d = 1'b0;
        if (verify_bad) begin
          verify_err_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, MEM/WB register and sticky flags with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 1'b0;
      rd_w_q         <= 5'd0;
      alu_result_w_q <= 32'd0;
      read_data_w_q  <= 32'd0;
      pc_plus4_w_q   <= 32'd0;
      parity_err_q   <= 1'b0;
      verify_err_q   <= 1'b0;
      align_err_q    <= 1'b0;
      vaddr_q        <= '0;
      vdata_q        <= 32'd0;
    end else begin
      state_q        <= state_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      parity_err_q   <= parity_err_d;
      verify_err_q   <= verify_err_d;
      align_err_q    <= align_err_d;
      vaddr_q        <= vaddr_d;
      vdata_q        <= vdata_d;
    end
  end

  // Data array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign mem_busy           = (state_q == S_VERIFY);
  assign RegWriteW          = reg_write_w_q;
  assign ResultSrcW         = result_src_w_q;
  assign RD_W               = rd_w_q;
  assign ALU_ResultW        = alu_result_w_q;
  assign ReadDataW          = read_data_w_q;
  assign PCPlus4W           = pc_plus4_w_q;
  assign parity_err_sticky  = parity_err_q;
  assign verify_err_sticky  = verify_err_q;
  assign align_err_sticky   = align_err_q;
  assign mem_fault_detected = parity_err_q | verify_err_q | align_err_q;

endmodule
`default_nettype wire
